// File: rtl/fifo_pkg.sv
// Shared types and helpers for the credit-based fifo writer.
package fifo_pkg;

  typedef enum logic [1:0] {CTX_INIT, CTX_RUN, CTX_DRAIN} ctx_state_t;

  // Counter width able to hold every value 0..depth inclusive.
  function automatic int crd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_credit_tx_if.sv
// Upstream valid/ready plus remote fifo push/credit-return signals of fifo_credit_tx.
interface fifo_credit_tx_if #(
  parameter int WIDTH = 4
) ();
  logic             in_val;
  logic [WIDTH-1:0] in_dat;
  logic             in_rdy;
  logic             psh;
  logic [WIDTH-1:0] din;
  logic             crd_ret;

  // master: the credit writer itself; slave: upstream source plus remote fifo
  modport master (
    input  in_val, in_dat, crd_ret,
    output in_rdy, psh, din
  );

  modport slave (
    output in_val, in_dat, crd_ret,
    input  in_rdy, psh, din
  );
endinterface

// File: rtl/fifo_credit_tx_ctr.sv
// Up/down credit counter, loads DEPTH on rst and saturates at DEPTH.
// Optional sticky overflow flag built only when FIFO_CREDIT_CHK_EN is defined.
module credit_ctr
  import fifo_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CRD_W = crd_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CRD_W-1:0] cnt,
  output logic             err
);

  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(DEPTH);

  logic [CRD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q != CRD_FULL) cnt_d = cnt_q + CRD_W'(1);
    end else if (dec && !inc) begin
      // dec is only ever asserted with cnt_q != 0
      cnt_d = cnt_q - CRD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= CRD_FULL;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

`ifdef FIFO_CREDIT_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (inc & ~dec & (cnt_q == CRD_FULL));
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/fifo_credit_tx.sv
// Credit-based push side for a remote fifo of DEPTH entries; registered psh/din.
// Optional credit overflow checker: define FIFO_CREDIT_CHK_EN.
//
// state     | meaning
// CTX_INIT  | one cycle after reset, remote fifo leaving reset, in_rdy=0
// CTX_RUN   | accepting words while credits remain
// CTX_DRAIN | no accepts; wait for all credits back and no push in flight
module fifo_credit_tx
  import fifo_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  DEPTH = 2,
  localparam int CRD_W = crd_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  fifo_credit_tx_if.master bus,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [CRD_W-1:0] crd_cnt,
  output logic             idle,
  output logic             crd_err
);

  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(DEPTH);

  ctx_state_t       state_q, state_d;
  logic             psh_q, psh_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             in_rdy;
  logic             accept;
  logic             drain_done_c;

  always_comb begin
    state_d      = state_q;
    in_rdy       = 1'b0;
    drain_done_c = 1'b0;
    case (state_q)
      CTX_INIT: state_d = CTX_RUN;
      CTX_RUN: begin
        in_rdy = (crd_cnt != '0);
        if (drain_req) state_d = CTX_DRAIN;
      end
      CTX_DRAIN: begin
        if (crd_cnt == CRD_FULL && !psh_q) begin
          state_d      = CTX_RUN;
          drain_done_c = 1'b1;
        end
      end
      default: state_d = CTX_INIT;
    endcase
  end

  assign accept = bus.in_val & in_rdy;

  always_comb begin
    psh_d = accept;
    din_d = accept ? bus.in_dat : din_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CTX_INIT;
      psh_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      psh_q   <= psh_d;
      din_q   <= din_d;
    end
  end

  // Credits are taken at accept so the register stage never oversubscribes the remote fifo.
  credit_ctr #(
    .DEPTH (DEPTH)
  ) u_credit_ctr (
    .clk (clk),
    .rst (rst),
    .inc (bus.crd_ret),
    .dec (accept),
    .cnt (crd_cnt),
    .err (crd_err)
  );

  assign bus.in_rdy = in_rdy;
  assign bus.psh    = psh_q;
  assign bus.din    = din_q;
  assign drain_done = drain_done_c;
  assign idle       = (crd_cnt == CRD_FULL) && !psh_q;

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Self-checking bench for fifo_credit_tx: cycle model plus din scoreboard queue.
module tb_fifo_credit_tx;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CRD_W = 2;

  logic             clk;
  logic             rst;
  logic             drain_req;
  logic             drain_done;
  logic [CRD_W-1:0] crd_cnt;
  logic             idle;
  logic             crd_err;

  fifo_credit_tx_if #(.WIDTH(WIDTH)) bif ();

  fifo_credit_tx #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bif),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .crd_cnt    (crd_cnt),
    .idle       (idle),
    .crd_err    (crd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // model state: 0 init, 1 run, 2 drain
  int   m_state;
  int   m_cnt;
  logic m_psh;
  logic m_err;
  logic [WIDTH-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = DEPTH;
    m_psh   = 1'b0;
    m_err   = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bif.in_val  = 1'b0;
    bif.in_dat  = '0;
    bif.crd_ret = 1'b0;
    drain_req   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at negedge: drive inputs, check outputs, advance the model one clock.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic cr, input logic dr);
    logic m_rdy, m_done, acc;
    logic [WIDTH-1:0] exp_din;
    bif.in_val  = v;
    bif.in_dat  = d;
    bif.crd_ret = cr;
    drain_req   = dr;
    m_rdy  = (m_state == 1) && (m_cnt != 0);
    m_done = (m_state == 2) && (m_cnt == DEPTH) && !m_psh;
    chk("in_rdy", bif.in_rdy, m_rdy);
    chk("crd_cnt", crd_cnt, m_cnt);
    chk("psh", bif.psh, m_psh);
    chk("idle", idle, (m_cnt == DEPTH) && !m_psh);
    chk("drain_done", drain_done, m_done);
    chk("crd_err", crd_err, m_err);
    if (bif.psh) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        exp_din = sb_q.pop_front();
        chk("din", bif.din, exp_din);
      end
    end
    acc = v & m_rdy;
    if (acc) sb_q.push_back(d);
    @(posedge clk);
    if (cr && !acc) begin
`ifdef FIFO_CREDIT_CHK_EN
      if (m_cnt == DEPTH) m_err = 1'b1;
`endif
      if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
    end else if (acc && !cr) begin
      m_cnt = m_cnt - 1;
    end
    m_psh = acc;
    case (m_state)
      0:       m_state = 1;
      1:       m_state = dr ? 2 : 1;
      default: m_state = m_done ? 1 : 2;
    endcase
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    model_reset();
    do_reset();

    // reset release: INIT then RUN with full credits
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // burst A, B until credits exhausted
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // credit return then accept C
    step(1'b1, 4'hC, 1'b1, 1'b0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // accept and crd_ret in the same cycle at crd_cnt=1
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'hD, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    // drain with two words outstanding, second accepted alongside drain_req
    step(1'b1, 4'hE, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0, 1'b1);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b1);
    step(1'b1, 4'h3, 1'b1, 1'b0);
    step(1'b1, 4'h4, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // overflow: crd_ret at full credit
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // reset mid-operation drops the pending push and clears crd_err
    step(1'b1, 4'h7, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // randomized streaming with occasional drains
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
